// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-clock RAM (1-cycle read latency, write-first)
// between two requesters: port 0 (CPU datapath) and port 1 (debug/loader).
// Round-robin per access, with an optional lock that lets the holder keep the
// RAM across back-to-back accesses, bounded by MAX_LOCK cycles.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   req/we/addr/wdata/lock 0,1 requester inputs (req held until granted)
//   gnt0/gnt1                  combinational grant, access issued this cycle
//   rvalid0/rvalid1            registered read-return strobes
//   rdata                      shared read data (= ram_dout)
//   lock_err                   sticky, a lock was force-released
//   ram_raddr/waddr/din/we     RAM drive from the winner
//   ram_dout                   RAM read data
module ram_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int MAX_LOCK   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  input  logic                  lock0,
  input  logic                  lock1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  lock_err,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  localparam int CW = $clog2(MAX_LOCK) + 1;

  typedef enum logic [1:0] {S_IDLE, S_LOCK0, S_LOCK1} state_t;

  state_t          r_state, w_state_nxt;
  logic            r_last, w_last_nxt;      // index of port granted most recently
  logic [CW-1:0]   r_lock_cnt, w_cnt_nxt;
  logic            r_rv0, r_rv1;
  logic            r_lock_err, w_lock_err_nxt;
  logic            w_gnt0, w_gnt1;
  logic            w_cnt_max;

  assign w_cnt_max = (r_lock_cnt == CW'(MAX_LOCK - 1));

  // Grant: round-robin tie-break in IDLE, exclusive to the holder while locked.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req0 && req1) begin
          if (r_last) w_gnt0 = 1'b1;
          else        w_gnt1 = 1'b1;
        end else begin
          w_gnt0 = req0;
          w_gnt1 = req1;
        end
      end
      S_LOCK0: w_gnt0 = req0;
      S_LOCK1: w_gnt1 = req1;
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_lock_cnt;
    w_last_nxt     = r_last;
    w_lock_err_nxt = r_lock_err;
    if (w_gnt0)      w_last_nxt = 1'b0;
    else if (w_gnt1) w_last_nxt = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (w_gnt0 && lock0) begin
          w_state_nxt = S_LOCK0;
          w_cnt_nxt   = CW'(1);
        end else if (w_gnt1 && lock1) begin
          w_state_nxt = S_LOCK1;
          w_cnt_nxt   = CW'(1);
        end
      end
      S_LOCK0: begin
        w_cnt_nxt = r_lock_cnt + CW'(1);
        if (!lock0) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (w_cnt_max) begin
          // Forced release: holder becomes "last" so port 1 wins the next tie.
          w_state_nxt    = S_IDLE;
          w_cnt_nxt      = '0;
          w_lock_err_nxt = 1'b1;
          w_last_nxt     = 1'b0;
        end
      end
      S_LOCK1: begin
        w_cnt_nxt = r_lock_cnt + CW'(1);
        if (!lock1) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (w_cnt_max) begin
          w_state_nxt    = S_IDLE;
          w_cnt_nxt      = '0;
          w_lock_err_nxt = 1'b1;
          w_last_nxt     = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_last     <= 1'b1;
      r_lock_cnt <= '0;
      r_rv0      <= 1'b0;
      r_rv1      <= 1'b0;
      r_lock_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_last     <= w_last_nxt;
      r_lock_cnt <= w_cnt_nxt;
      r_rv0      <= w_gnt0 & ~we0;
      r_rv1      <= w_gnt1 & ~we1;
      r_lock_err <= w_lock_err_nxt;
    end
  end

  // RAM drive from the winner; idle bus when nothing is granted.
  always_comb begin
    ram_raddr = '0;
    ram_waddr = '0;
    ram_din   = '0;
    ram_we    = 1'b0;
    if (w_gnt0) begin
      ram_raddr = addr0;
      ram_waddr = addr0;
      ram_din   = wdata0;
      ram_we    = we0;
    end else if (w_gnt1) begin
      ram_raddr = addr1;
      ram_waddr = addr1;
      ram_din   = wdata1;
      ram_we    = we1;
    end
  end

  assign gnt0     = w_gnt0;
  assign gnt1     = w_gnt1;
  assign rvalid0  = r_rv0;
  assign rvalid1  = r_rv1;
  assign rdata    = ram_dout;
  assign lock_err = r_lock_err;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural write-first RAM attached.
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, we0, we1, lock0, lock1;
  logic [4:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1, lock_err, ram_we;
  logic [7:0] rdata, ram_din, ram_dout;
  logic [4:0] ram_raddr, ram_waddr;
  logic [7:0] mem [32];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .MAX_LOCK(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .lock0(lock0), .lock1(lock1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .lock_err(lock_err),
    .ram_raddr(ram_raddr), .ram_waddr(ram_waddr), .ram_din(ram_din),
    .ram_we(ram_we), .ram_dout(ram_dout)
  );

  // Write-first RAM, 1-cycle read latency; preloaded while rst is high.
  always @(posedge clk) begin
    if (rst) begin
      mem[2] <= 8'h11;
      mem[3] <= 8'h3C;
      mem[7] <= 8'h77;
    end else if (ram_we) begin
      mem[ram_waddr] <= ram_din;
    end
    ram_dout <= (ram_we && ram_waddr == ram_raddr) ? ram_din : mem[ram_raddr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_rv0", rvalid0, 0);
    chk("rst_rv1", rvalid1, 0);
    chk("rst_lockerr", lock_err, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_raddr", ram_raddr, 0);
    tick;

    // Both ports read together: port 0 wins the first tie.
    req0 = 1; addr0 = 5'd3; req1 = 1; addr1 = 5'd7;
    #1;
    chk("t1_gnt0", gnt0, 1);
    chk("t1_gnt1", gnt1, 0);
    chk("t1_raddr", ram_raddr, 3);
    chk("t1_we", ram_we, 0);
    tick;
    req0 = 0;
    #1;
    chk("t1_c2_gnt1", gnt1, 1);
    chk("t1_c2_gnt0", gnt0, 0);
    chk("t1_c2_raddr", ram_raddr, 7);
    chk("t1_c2_rv0", rvalid0, 1);
    chk("t1_c2_rdata", rdata, 8'h3C);
    chk("t1_c2_rv1", rvalid1, 0);
    tick;
    req1 = 0;
    #1;
    chk("t1_c3_rv1", rvalid1, 1);
    chk("t1_c3_rdata", rdata, 8'h77);
    chk("t1_c3_rv0", rvalid0, 0);
    chk("t1_c3_gnt1", gnt1, 0);
    tick;

    // Port 0 write, then port 1 reads it back.
    req0 = 1; we0 = 1; addr0 = 5'd5; wdata0 = 8'hA5;
    #1;
    chk("t2_gnt0", gnt0, 1);
    chk("t2_we", ram_we, 1);
    chk("t2_waddr", ram_waddr, 5);
    chk("t2_din", ram_din, 8'hA5);
    tick;
    req0 = 0; we0 = 0; req1 = 1; addr1 = 5'd5;
    #1;
    chk("t2_gnt1", gnt1, 1);
    chk("t2_we_rd", ram_we, 0);
    chk("t2_no_rv0", rvalid0, 0);
    tick;
    req1 = 0;
    #1;
    chk("t2_rv1", rvalid1, 1);
    chk("t2_rdata", rdata, 8'hA5);
    chk("t2_rv0_still0", rvalid0, 0);
    tick;

    // Port 0 locked read-modify-write while port 1 keeps requesting.
    req0 = 1; we0 = 0; addr0 = 5'd2; lock0 = 1; req1 = 1; addr1 = 5'd9;
    #1;
    chk("t3_rd_gnt0", gnt0, 1);
    chk("t3_rd_gnt1", gnt1, 0);
    tick;
    we0 = 1; wdata0 = 8'h12; lock0 = 0;
    #1;
    chk("t3_wr_gnt0", gnt0, 1);
    chk("t3_wr_gnt1", gnt1, 0);
    chk("t3_wr_we", ram_we, 1);
    chk("t3_wr_waddr", ram_waddr, 2);
    chk("t3_wr_din", ram_din, 8'h12);
    chk("t3_rv0", rvalid0, 1);
    chk("t3_rdata", rdata, 8'h11);
    tick;
    req0 = 0; we0 = 0;
    #1;
    chk("t3_gnt1", gnt1, 1);
    chk("t3_gnt0", gnt0, 0);
    chk("t3_raddr", ram_raddr, 9);
    chk("t3_lockerr", lock_err, 0);
    tick;

    // Port 1 holds its lock: forced release after 8 locked cycles.
    req1 = 1; lock1 = 1; addr1 = 5'd7;
    #1;
    chk("t4_first_gnt1", gnt1, 1);
    tick;
    req0 = 1; addr0 = 5'd4;
    for (int i = 0; i < 7; i++) begin
      #1;
      chk($sformatf("t4_lk%0d_gnt1", i), gnt1, 1);
      chk($sformatf("t4_lk%0d_gnt0", i), gnt0, 0);
      chk($sformatf("t4_lk%0d_err", i), lock_err, 0);
      tick;
    end
    #1;
    chk("t4_rel_gnt0", gnt0, 1);
    chk("t4_rel_gnt1", gnt1, 0);
    chk("t4_rel_raddr", ram_raddr, 4);
    chk("t4_rel_err", lock_err, 1);
    tick;
    req0 = 0; req1 = 0; lock1 = 0;
    #1;
    chk("t4_err_sticky", lock_err, 1);
    chk("t4_idle_gnt0", gnt0, 0);
    chk("t4_idle_gnt1", gnt1, 0);
    tick;

    // Reset in the middle of a lock with a read just granted.
    req0 = 1; addr0 = 5'd3; lock0 = 1;
    #1;
    chk("t5_gnt0", gnt0, 1);
    tick;
    rst = 1;
    #1;
    chk("t5_pre_rv0", rvalid0, 1);
    chk("t5_pre_gnt0", gnt0, 1);
    tick;
    rst = 0; lock0 = 0; req1 = 1; addr1 = 5'd7;
    #1;
    chk("t5_rv0_dropped", rvalid0, 0);
    chk("t5_lockerr_clr", lock_err, 0);
    chk("t5_tie_gnt0", gnt0, 1);
    chk("t5_tie_gnt1", gnt1, 0);
    tick;
    #1;
    chk("t5_next_gnt1", gnt1, 1);
    chk("t5_next_gnt0", gnt0, 0);
    chk("t5_next_rv0", rvalid0, 1);
    chk("t5_next_rdata", rdata, 8'h3C);
    tick;
    req0 = 0; req1 = 0;
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
